mar_ctr: RTL and testbench

MAR_CTR -- requirements
Module: mar_ctr

---
 rtl/mar_ctr.sv | 74 +++++++
 tb/tb_mar_ctr.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/mar_ctr.sv
// Memory address register with single-step increment and counted burst mode.
// Optional build macro MAR_CTR_SAT_EN: increments saturate at all-ones instead of wrapping.
module mar_ctr #(
    parameter int AW = 8,
    parameter int BW = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [AW-1:0] D,
    input  logic          IMAR,
    input  logic          INC,
    input  logic          BST,
    input  logic [BW-1:0] BLEN,
    output logic [AW-1:0] ABUS,
    output logic          BUSY,
    output logic          DONE,
    output logic          WRAP
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam logic [AW-1:0] A_ONE = AW'(1);
    localparam logic [BW-1:0] C_ONE = BW'(1);

    state_t        state;
    logic [BW-1:0] cnt;
    logic          at_max;
    logic [AW-1:0] abus_inc;

    assign at_max = &ABUS;

`ifdef MAR_CTR_SAT_EN
    assign abus_inc = at_max ? ABUS : ABUS + A_ONE;
`else
    assign abus_inc = ABUS + A_ONE;
`endif

    assign BUSY = (state == BURST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; DONE/WRAP default low so they act as pulses.
    always_ff @(posedge CLK) begin
        DONE <= 1'b0;
        WRAP <= 1'b0;
        if (RST) begin
            ABUS  <= '0;
            cnt   <= '0;
            state <= IDLE;
        end else if (IMAR) begin
            // A load aborts any burst silently.
            ABUS  <= D;
            cnt   <= '0;
            state <= IDLE;
        end else if (state == BURST) begin
            ABUS <= abus_inc;
            WRAP <= at_max;
            cnt  <= cnt - C_ONE;
            if (cnt == C_ONE) begin
                state <= IDLE;
                DONE  <= 1'b1;
            end
        end else if (BST && (BLEN != '0)) begin
            cnt   <= BLEN;
            state <= BURST;
        end else if (INC) begin
            ABUS <= abus_inc;
            WRAP <= at_max;
        end
    end

endmodule

// File: tb/tb_mar_ctr.sv
// Self-checking bench for mar_ctr: directed scenarios plus random traffic
// compared against an integer-level model of remaining burst steps.
module tb_mar_ctr;

    localparam int AW   = 8;
    localparam int BW   = 4;
    localparam int AMAX = (1 << AW) - 1;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic [AW-1:0] D = '0;
    logic          IMAR = 1'b0;
    logic          INC = 1'b0;
    logic          BST = 1'b0;
    logic [BW-1:0] BLEN = '0;
    logic [AW-1:0] ABUS;
    logic          BUSY;
    logic          DONE;
    logic          WRAP;

    int total = 0;
    int bad   = 0;

    // Model: address as an integer, remaining burst steps, pending pulses.
    int m_addr = 0;
    int m_left = 0;
    bit m_done = 1'b0;
    bit m_wrap = 1'b0;

    mar_ctr #(.AW(AW), .BW(BW)) dut (
        .CLK(CLK), .RST(RST), .D(D), .IMAR(IMAR), .INC(INC), .BST(BST),
        .BLEN(BLEN), .ABUS(ABUS), .BUSY(BUSY), .DONE(DONE), .WRAP(WRAP)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_step_addr();
        if (m_addr == AMAX) begin
            m_wrap = 1'b1;
`ifdef MAR_CTR_SAT_EN
            m_addr = AMAX;
`else
            m_addr = 0;
`endif
        end else begin
            m_addr = m_addr + 1;
        end
    endfunction

    function automatic void model_edge(bit rst, bit imar, int d, bit inc, bit bst, int blen);
        m_done = 1'b0;
        m_wrap = 1'b0;
        if (rst) begin
            m_addr = 0;
            m_left = 0;
        end else if (imar) begin
            m_addr = d;
            m_left = 0;
        end else if (m_left > 0) begin
            model_step_addr();
            m_left = m_left - 1;
            if (m_left == 0) m_done = 1'b1;
        end else if (bst && blen != 0) begin
            m_left = blen;
        end else if (inc) begin
            model_step_addr();
        end
    endfunction

    // Apply one clock of inputs, advance the model, compare all outputs #1 after the edge.
    task automatic cycle(input string tag, input bit rst, input bit imar, input int d,
                         input bit inc, input bit bst, input int blen);
        RST  = rst;
        IMAR = imar;
        D    = AW'(d);
        INC  = inc;
        BST  = bst;
        BLEN = BW'(blen);
        @(posedge CLK);
        model_edge(rst, imar, d, inc, bst, blen);
        #1;
        check({tag, ".abus"}, 32'(ABUS), 32'(m_addr));
        check({tag, ".busy"}, 32'(BUSY), 32'(m_left > 0));
        check({tag, ".done"}, 32'(DONE), 32'(m_done));
        check({tag, ".wrap"}, 32'(WRAP), 32'(m_wrap));
    endtask

    task automatic idle(input string tag);
        cycle(tag, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0);
    endtask

    initial begin
        // Reset overrides a simultaneous load.
        cycle("rst", 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 0);
        check("rst.abus_lit", 32'(ABUS), 32'h00);
        check("rst.busy_lit", 32'(BUSY), 32'h0);

        // Load then three single steps.
        cycle("ld10", 1'b0, 1'b1, 8'h10, 1'b0, 1'b0, 0);
        check("ld10.lit", 32'(ABUS), 32'h10);
        for (int i = 0; i < 3; i++) cycle("inc", 1'b0, 1'b0, 0, 1'b1, 1'b0, 0);
        check("inc.lit", 32'(ABUS), 32'h13);

        // Four-step burst from 0x20.
        cycle("ld20", 1'b0, 1'b1, 8'h20, 1'b0, 1'b0, 0);
        cycle("bst4", 1'b0, 1'b0, 0, 1'b1, 1'b1, 4);
        check("bst4.hold", 32'(ABUS), 32'h20);
        for (int i = 0; i < 4; i++) cycle("b4", 1'b0, 1'b0, 0, 1'b1, 1'b1, 4);
        check("b4.end_lit", 32'(ABUS), 32'h24);
        check("b4.done_lit", 32'(DONE), 32'h1);
        idle("b4.after");

        // Burst across the top of the address space.
        cycle("ldfe", 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, 0);
        cycle("bst3", 1'b0, 1'b0, 0, 1'b0, 1'b1, 3);
        for (int i = 0; i < 3; i++) idle("b3");
`ifdef MAR_CTR_SAT_EN
        check("b3.end_lit", 32'(ABUS), 32'hFF);
`else
        check("b3.end_lit", 32'(ABUS), 32'h01);
`endif
        idle("b3.after");

        // Load aborts an eight-step burst on its third busy cycle.
        cycle("ld40", 1'b0, 1'b1, 8'h40, 1'b0, 1'b0, 0);
        cycle("bst8", 1'b0, 1'b0, 0, 1'b0, 1'b1, 8);
        idle("b8.1");
        idle("b8.2");
        cycle("abort", 1'b0, 1'b1, 8'h77, 1'b0, 1'b0, 0);
        check("abort.lit", 32'(ABUS), 32'h77);
        check("abort.done_lit", 32'(DONE), 32'h0);
        idle("abort.after");

        // Priority: load beats BST/INC; zero-length BST lets INC through.
        cycle("prio", 1'b0, 1'b1, 8'h05, 1'b1, 1'b1, 5);
        check("prio.lit", 32'(ABUS), 32'h05);
        cycle("blen0", 1'b0, 1'b0, 0, 1'b1, 1'b1, 0);
        check("blen0.lit", 32'(ABUS), 32'h06);
        check("blen0.busy_lit", 32'(BUSY), 32'h0);

        // Reset mid-burst: no DONE.
        cycle("bst5", 1'b0, 1'b0, 0, 1'b0, 1'b1, 5);
        idle("b5.1");
        cycle("rst_mid", 1'b1, 1'b0, 0, 1'b0, 1'b0, 0);
        idle("rst_mid.after");

        // Single-step wrap at the top.
        cycle("ldff", 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 0);
        cycle("incff", 1'b0, 1'b0, 0, 1'b1, 1'b0, 0);
        check("incff.wrap_lit", 32'(WRAP), 32'h1);
        idle("incff.after");

        // Random traffic; loads favour the top of the range to exercise wrap.
        for (int i = 0; i < 600; i++) begin
            int  sel;
            int  d;
            bit  r;
            sel = int'($urandom_range(0, 3));
            d   = (sel == 0) ? AMAX : (sel == 1) ? AMAX - 1 : int'($urandom_range(0, AMAX));
            r   = ($urandom_range(0, 99) < 2);
            cycle("rnd", r, ($urandom_range(0, 99) < 10), d, bit'($urandom_range(0, 1)),
                  ($urandom_range(0, 99) < 25), int'($urandom_range(0, (1 << BW) - 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
